// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubble insertion, EX hold with forwarded-operand capture.
// Optional ID_EX_PERF_EN adds saturating bubble/hold event counters.
`ifndef W_OPER
`define W_OPER 6
`endif
`ifndef W_REGF
`define W_REGF 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif

module id_ex_stage #(
    parameter logic [`W_OPER-1:0] NOP_OPER = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hz_stall,
    input  logic               ex_hold,
    input  logic               flush_id,
    input  logic               flush_ex,
    input  logic               id_valid,
    input  logic [`W_OPER-1:0] id_oper,
    input  logic [`W_REGF-1:0] id_rs,
    input  logic [`W_REGF-1:0] id_rt,
    input  logic [`W_REGF-1:0] id_regf,
    input  logic [`W_DATA-1:0] id_rs_data,
    input  logic [`W_DATA-1:0] id_rt_data,
    input  logic [`W_DATA-1:0] id_imm,
    input  logic [`W_DATA-1:0] id_pc,
    input  logic               fwd_rs,
    input  logic               fwd_rt,
    input  logic [`W_DATA-1:0] fwd_rs_data,
    input  logic [`W_DATA-1:0] fwd_rt_data,
    output logic               ex_valid,
    output logic [`W_OPER-1:0] ex_oper,
    output logic [`W_REGF-1:0] ex_rs,
    output logic [`W_REGF-1:0] ex_rt,
    output logic [`W_REGF-1:0] ex_regf,
    output logic [`W_DATA-1:0] ex_rs_val,
    output logic [`W_DATA-1:0] ex_rt_val,
    output logic [`W_DATA-1:0] ex_imm,
    output logic [`W_DATA-1:0] ex_pc,
`ifdef ID_EX_PERF_EN
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_hold_cnt,
`endif
    output logic               id_ready
);

    logic               valid_q, valid_d;
    logic [`W_OPER-1:0] oper_q,  oper_d;
    logic [`W_REGF-1:0] rs_q,    rs_d;
    logic [`W_REGF-1:0] rt_q,    rt_d;
    logic [`W_REGF-1:0] regf_q,  regf_d;
    logic [`W_DATA-1:0] rs_val_q, rs_val_d;
    logic [`W_DATA-1:0] rt_val_q, rt_val_d;
    logic [`W_DATA-1:0] imm_q,   imm_d;
    logic [`W_DATA-1:0] pc_q,    pc_d;
    logic               take_bubble;
    logic               take_hold;

    assign take_hold   = ~flush_ex & ex_hold;
    assign take_bubble = flush_ex | (~ex_hold & (hz_stall | flush_id | ~id_valid));

    always_comb begin
        valid_d  = valid_q;
        oper_d   = oper_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        regf_d   = regf_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        if (take_bubble) begin
            valid_d  = 1'b0;
            oper_d   = NOP_OPER;
            rs_d     = '0;
            rt_d     = '0;
            regf_d   = '0;
            rs_val_d = '0;
            rt_val_d = '0;
            imm_d    = '0;
            pc_d     = '0;
        end else if (take_hold) begin
            // Keep absorbing forwards so a producer retiring during the hold is not lost
            rs_val_d = fwd_rs ? fwd_rs_data : rs_val_q;
            rt_val_d = fwd_rt ? fwd_rt_data : rt_val_q;
        end else begin
            valid_d  = 1'b1;
            oper_d   = id_oper;
            rs_d     = id_rs;
            rt_d     = id_rt;
            regf_d   = id_valid ? id_regf : '0;
            rs_val_d = id_rs_data;
            rt_val_d = id_rt_data;
            imm_d    = id_imm;
            pc_d     = id_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            oper_q   <= NOP_OPER;
            rs_q     <= '0;
            rt_q     <= '0;
            regf_q   <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            oper_q   <= oper_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            regf_q   <= regf_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_oper   = oper_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_regf   = regf_q;
    assign ex_imm    = imm_q;
    assign ex_pc     = pc_q;
    assign ex_rs_val = fwd_rs ? fwd_rs_data : rs_val_q;
    assign ex_rt_val = fwd_rt ? fwd_rt_data : rt_val_q;
    assign id_ready  = ~ex_hold & ~hz_stall;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] hold_cnt_q,   hold_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (take_bubble && bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 32'd1;
        if (take_hold && hold_cnt_q != '1)     hold_cnt_d   = hold_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_hold_cnt   = hold_cnt_q;
`endif

endmodule
